// File: rtl/cla_sum_accumulator.sv
// ---------------------------------------------------------------------------
// cla_sum_accumulator
//
// Purpose:
//   Sits behind the registered 5-bit CLA adder stage. Each adder result
//   {cout, sum} is taken as a 6-bit unsigned term. NUM_TERMS terms are
//   summed into an ACC_W-bit total, and the total is then offered to the
//   next stage over a valid/ready handshake. A sticky flag records whether
//   any partial sum in the batch went past 2^ACC_W-1. A synchronous clear
//   throws away the current batch or any pending result.
//
// Parameters:
//   NUM_TERMS  terms per batch (2..255)
//   ACC_W      accumulator / result width in bits (>= 6)
//
// Ports:
//   clk        clock, all state changes on the rising edge
//   rst        asynchronous active-high reset
//   clr        synchronous batch flush, active-high
//   in_valid   sum/cout carry a valid adder result
//   sum        adder sum bits (term bits 4:0)
//   cout       adder carry-out (term bit 5)
//   in_ready   block accepts a term this cycle
//   out_valid  acc_out/overflow hold a completed batch
//   out_ready  downstream accepts the result
//   acc_out    batch total modulo 2^ACC_W
//   overflow   some partial sum of the batch exceeded 2^ACC_W-1
//   term_cnt   terms accepted in the current batch
// ---------------------------------------------------------------------------
module cla_sum_accumulator #(
  parameter int NUM_TERMS = 4,
  parameter int ACC_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [4:0]       sum,
  input  logic             cout,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [7:0]       term_cnt
);

  // ACCUM collects terms. DONE holds the finished batch until the
  // downstream stage takes it.
  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_t;

  // Count value that the final term of a batch is accepted at.
  localparam logic [7:0] LAST_CNT = 8'(NUM_TERMS - 1);

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             handoff;
  logic             last_term;
  logic [ACC_W:0]   term_ext;
  logic [ACC_W:0]   partial;

  // The term is zero-extended one bit past the accumulator width. The
  // extra bit of the partial sum is the wrap indication for that step.
  assign term_ext = {{(ACC_W - 5){1'b0}}, cout, sum};
  assign partial  = {1'b0, acc_out} + term_ext;

  // Handshake outputs are decoded from the state register. in_ready is
  // also masked by rst so nothing looks acceptable while reset is held.
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    if (state == ACCUM) begin
      in_ready = !rst;
    end else begin
      out_valid = 1'b1;
    end
  end

  assign accept    = in_valid && in_ready;
  assign handoff   = out_valid && out_ready;
  assign last_term = (term_cnt == LAST_CNT);

  // Next-state logic. clr overrides everything else, so a pending result
  // is discarded even when out_ready is high in the same cycle.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM: begin
          if (accept && last_term) begin
            state_nxt = DONE;
          end
        end
        DONE: begin
          if (handoff) begin
            state_nxt = ACCUM;
          end
        end
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ACCUM;
    end else begin
      state <= state_nxt;
    end
  end

  // Accumulator, sticky wrap flag and term counter. In DONE, accept is
  // always low, so the result stays frozen until the handoff clears it.
  // A term presented during clr or during the handoff cycle is not counted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_out  <= '0;
      overflow <= 1'b0;
      term_cnt <= 8'd0;
    end else if (clr || handoff) begin
      acc_out  <= '0;
      overflow <= 1'b0;
      term_cnt <= 8'd0;
    end else if (accept) begin
      acc_out  <= partial[ACC_W-1:0];
      overflow <= overflow | partial[ACC_W];
      term_cnt <= term_cnt + 8'd1;
    end
  end

endmodule

// File: doc/cla_sum_accumulator.md
Name: cla_sum_accumulator

Overview:
- Downstream consumer of the registered 5-bit CLA adder stage.
- Captures each {cout, sum} result as a 6-bit unsigned term and accumulates NUM_TERMS terms into an ACC_W-bit total.
- Presents the total on a valid/ready output handshake to the next stage.
- Provides an input handshake, wrap detection and a synchronous batch flush.

Parameters:
- NUM_TERMS, 4, terms per batch (legal range 2..255).
- ACC_W, 8, accumulator and result width in bits (≥6).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  asynchronous, active-high reset
- clr  input  1  synchronous batch flush, active-high
- in_valid  input  1  sum/cout hold a valid adder result
- sum  input  5  adder sum bits
- cout  input  1  adder carry-out, bit 5 of the term
- in_ready  output  1  block accepts a term this cycle
- out_valid  output  1  acc_out/overflow hold a completed batch
- out_ready  input  1  downstream accepts the result
- acc_out  output  ACC_W  batch total modulo 2^ACC_W
- overflow  output  1  batch total exceeded 2^ACC_W-1
- term_cnt  output  8  terms accepted in the current batch

Behaviour:
- Reset (async, rst=1): state=ACCUM, acc_out=0, overflow=0, term_cnt=0, out_valid=0, in_ready=1 (combinational from state, masked to 0 while rst=1).
- term = {cout, sum}, zero-extended to ACC_W+1 bits. The sum is computed at ACC_W+1 bits; bit ACC_W of each partial sum ORs into a running sticky wrap flag.
- State ACCUM:
  - in_ready=1, out_valid=0.
  - Accept when in_valid&in_ready: acc<=acc+term, term_cnt<=term_cnt+1.
  - Accept with term_cnt==NUM_TERMS-1 moves to DONE. The final term is included in acc. acc_out/overflow are registered.
  - out_valid rises the cycle after the final accept (1-cycle latency).
- State DONE:
  - out_valid=1, in_ready=0. in_valid is ignored and terms are not consumed.
  - acc_out, overflow and term_cnt (=NUM_TERMS) are held stable while out_valid && !out_ready.
  - out_valid&&out_ready: next cycle go to ACCUM with acc=0, overflow=0, term_cnt=0.
  - No accept occurs in the handoff cycle; the earliest next accept is the following cycle.
- in_valid gaps: allowed at any time in ACCUM. State and count are unchanged.
- Sources must not change sum/cout while in_valid&&!in_ready. Aligning in_valid with the adder's 1-cycle register latency is the source's duty.
- clr (synchronous, highest priority after rst):
  - In any state, the next state is ACCUM with acc=0, overflow=0, term_cnt=0, out_valid=0.
  - A term presented in the same cycle is dropped.
  - A pending DONE result is discarded even if out_ready=1.
- Wrap: acc_out is the true total mod 2^ACC_W. overflow=1 iff any partial sum in the batch exceeded 2^ACC_W-1.
- Reset mid-batch: all partial state is lost immediately. There is no output glitch other than out_valid/in_ready forced low/reset values.
- Maximum term is 62 (31+31). Any 6-bit value 0..63 must still be summed correctly.

FSM summary:
- ACCUM → DONE on the final accept.
- DONE → ACCUM on the out handshake or clr.
- ACCUM → ACCUM on clr.

Test Plan:
- Basic batch, defaults: terms 8,16,32,62 on consecutive cycles → out_valid one cycle after the 4th accept, acc_out=118 (0x76), overflow=0, term_cnt=4.
- Gapped input: terms 3,0,15,31 with in_valid low for 2 cycles between each → acc_out=49, overflow=0. term_cnt increments only on accepted cycles.
- Wrap, NUM_TERMS=5, ACC_W=8: five terms of 62 → acc_out=54 (310 mod 256), overflow=1. The next batch 1,1,1,1,1 → acc_out=5, overflow=0.
- Backpressure: complete a batch, then hold out_ready=0 for 3 cycles with in_valid=1, term=20.
  - out_valid, acc_out and overflow are stable; in_ready=0; no term consumed.
  - out_ready=1 → out_valid drops the next cycle. The next batch starts from 0 and its first accepted term is 20.
- clr mid-batch: accept 10,10, assert clr with in_valid=1, term=7 → term_cnt=0, acc reset, 7 dropped. Then 1,2,3,4 → acc_out=10.
- Async reset mid-batch and during DONE:
  - Assert rst between clock edges → outputs go to reset values immediately.
  - After release, a fresh batch of 5,5,5,5 → acc_out=20.
